// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save compressor rows and the resolver
// that turns their carry-save output into a binary sum.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } res_state_e;

    localparam int CSA_WIDTH = 17;
    localparam int CSA_CHUNK = 4;

    function automatic int nchunk(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/csa_resolver_chunk.sv
// One CHUNK-bit slice of the ripple adder; the resolver reuses it every cycle.
module csa_resolver_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/csa_resolver.sv
// Resolves one carry-save pair into a binary sum, CHUNK bits per cycle,
// with valid/ready handshakes on both sides.
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int CHUNK = CSA_CHUNK
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             busy
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int PW     = NCHUNK * CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    res_state_e       state;
    logic [PW-1:0]    op0;
    logic [PW-1:0]    op1;
    logic [PW:0]      result;
    logic [PW:0]      res_next;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             last;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic [WIDTH:0]   sum_fold;
    int               lo;

    // Accepting while DONE relies on out_ready only, never on in_valid.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign last     = (idx == IDX_W'(NCHUNK - 1));

    always_comb begin
        lo      = int'(idx) * CHUNK;
        chunk_a = op0[lo +: CHUNK];
        chunk_b = op1[lo +: CHUNK];
    end

    csa_resolver_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    always_comb begin
        res_next              = result;
        res_next[lo +: CHUNK] = chunk_sum;
        if (last) res_next[PW] = chunk_cout;
    end

    // Padding bits are zero, so OR-folding them into the top bit stays exact.
    assign sum_fold = {|res_next[PW:WIDTH], res_next[WIDTH-1:0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op0       <= '0;
            op1       <= '0;
            result    <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op0    <= PW'(in_0);
                        op1    <= PW'(in_1);
                        idx    <= '0;
                        carry  <= 1'b0;
                        result <= '0;
                        busy   <= 1'b1;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    result <= res_next;
                    carry  <= chunk_cout;
                    if (last) begin
                        idx       <= '0;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_sum   <= sum_fold;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            op0    <= PW'(in_0);
                            op1    <= PW'(in_1);
                            idx    <= '0;
                            carry  <= 1'b0;
                            result <= '0;
                            busy   <= 1'b1;
                            state  <= ADD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_resolver.sv
// Directed bench for csa_resolver: default geometry plus CHUNK=1 and CHUNK=17.
module tb_csa_resolver;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] in_0;
    logic [16:0] in_1;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_sum;
    logic        busy;

    logic        sw_valid;
    logic [16:0] sw_in_0;
    logic [16:0] sw_in_1;
    logic        sw_ready;
    logic        c1_in_ready, c1_out_valid, c1_busy;
    logic [17:0] c1_out_sum;
    logic        c17_in_ready, c17_out_valid, c17_busy;
    logic [17:0] c17_out_sum;

    int n_cmp = 0;
    int n_mis = 0;

    csa_resolver #(.WIDTH(17), .CHUNK(4)) u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_0(in_0), .in_1(in_1),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
    );

    csa_resolver #(.WIDTH(17), .CHUNK(1)) u_c1 (
        .clock(clock), .reset(reset),
        .in_valid(sw_valid), .in_ready(c1_in_ready), .in_0(sw_in_0), .in_1(sw_in_1),
        .out_valid(c1_out_valid), .out_ready(sw_ready), .out_sum(c1_out_sum), .busy(c1_busy)
    );

    csa_resolver #(.WIDTH(17), .CHUNK(17)) u_c17 (
        .clock(clock), .reset(reset),
        .in_valid(sw_valid), .in_ready(c17_in_ready), .in_0(sw_in_0), .in_1(sw_in_1),
        .out_valid(c17_out_valid), .out_ready(sw_ready), .out_sum(c17_out_sum), .busy(c17_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic accept(input logic [16:0] a, input logic [16:0] b, input bit hold, input string tag);
        int k = 0;
        while (!in_ready && k < 40) begin
            step();
            k++;
        end
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        in_0     = a;
        in_1     = b;
        in_valid = 1'b1;
        step();
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int exp_lat, input logic [17:0] exp_sum, input string tag);
        int cnt = 0;
        while (!out_valid && cnt < 40) begin
            step();
            cnt++;
        end
        check({tag, "_lat"}, 32'(cnt), 32'(exp_lat));
        check({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
    endtask

    initial begin
        int lat1, lat17, cyc;
        logic [17:0] sum1, sum17;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_0      = '0;
        in_1      = '0;
        out_ready = 1'b1;
        sw_valid  = 1'b0;
        sw_in_0   = '0;
        sw_in_1   = '0;
        sw_ready  = 1'b1;
        #2 reset  = 1'b0;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        reset = 1'b1;
        step();

        // Carry ripples through every chunk.
        accept(17'h00001, 17'h1FFFF, 1'b0, "t1");
        wait_valid(5, 18'h20000, "t1");
        step();

        // Top-bit fold out of the one-bit last chunk.
        accept(17'h1FFFF, 17'h1FFFF, 1'b0, "t2");
        wait_valid(5, 18'h3FFFE, "t2");
        step();

        // Input changes and held in_valid during ADD are ignored.
        out_ready = 1'b0;
        accept(17'h0ABCD, 17'h05432, 1'b1, "t3");
        in_0 = 17'h1FFFF;
        check("t3_busy_c0", 32'(busy), 32'd1);
        check("t3_rdy_c0", 32'(in_ready), 32'd0);
        step();
        check("t3_busy_c1", 32'(busy), 32'd1);
        check("t3_rdy_c1", 32'(in_ready), 32'd0);
        step();
        wait_valid(3, 18'h0FFFF, "t3");
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();

        // Backpressure then same-edge handoff.
        out_ready = 1'b0;
        accept(17'h1FFFF, 17'h1FFFF, 1'b0, "t4");
        wait_valid(5, 18'h3FFFE, "t4");
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_hold_sum", 32'(out_sum), 32'h3FFFE);
            check("t4_hold_vld", 32'(out_valid), 32'd1);
            check("t4_hold_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_0      = 17'h00002;
        in_1      = 17'h00003;
        in_valid  = 1'b1;
        #1;
        check("t4_handoff_rdy", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("t4_handoff_vld", 32'(out_valid), 32'd0);
        check("t4_handoff_busy", 32'(busy), 32'd1);
        wait_valid(5, 18'h00005, "t4b");
        step();

        // Reset at idx=2 abandons the operation.
        accept(17'h1FFFF, 17'h00001, 1'b0, "t5");
        step();
        step();
        check("t5_busy_pre", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("t5_rst_vld", 32'(out_valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_rdy", 32'(in_ready), 32'd1);
        check("t5_rst_sum", 32'(out_sum), 32'd0);
        step();
        reset = 1'b1;
        step();
        accept(17'h00010, 17'h00020, 1'b0, "t5b");
        wait_valid(5, 18'h00030, "t5b");
        step();

        // Geometry sweep: CHUNK=1 and CHUNK=17.
        lat1    = 0;
        lat17   = 0;
        sum1    = '0;
        sum17   = '0;
        sw_in_0 = 17'h1FFFF;
        sw_in_1 = 17'h00001;
        sw_valid = 1'b1;
        step();
        sw_valid = 1'b0;
        for (cyc = 1; cyc <= 30; cyc++) begin
            step();
            if (c1_out_valid && lat1 == 0) begin
                lat1 = cyc;
                sum1 = c1_out_sum;
            end
            if (c17_out_valid && lat17 == 0) begin
                lat17 = cyc;
                sum17 = c17_out_sum;
            end
        end
        check("c1_lat", 32'(lat1), 32'd17);
        check("c1_sum", 32'(sum1), 32'h20000);
        check("c17_lat", 32'(lat17), 32'd1);
        check("c17_sum", 32'(sum17), 32'h20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/csa_resolver.md
Name: csa_resolver

Overview:
- Consumer end of the carry-save compressor rows: accepts one carry-save pair (out_0/out_1 of a 4:2 row) and resolves it into a single binary sum.
- Uses a multi-cycle chunked ripple adder, CHUNK bits per cycle, so no full-width carry-propagate path is needed.
- Sits between the compressor tree and downstream binary consumers (accumulators, normalisers).
- Valid/ready handshake on both sides.

Parameters:
- WIDTH, 17, width of each carry-save input vector.
- CHUNK, 4, bits resolved per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, ceil(WIDTH/CHUNK) (derived, not overridable), number of ADD cycles; 5 at the defaults.

Ports:
- clock  input  1  sole clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  carry-save pair presented.
- in_ready  output  1  block can accept a pair this cycle.
- in_0  input  WIDTH  sum vector.
- in_1  input  WIDTH  carry vector, already weight-aligned by the producer.
- out_valid  output  1  out_sum holds a resolved result.
- out_ready  input  1  consumer takes the result this cycle.
- out_sum  output  WIDTH+1  in_0 + in_1, zero-extended, exact (never truncated).
- busy  output  1  high in ADD state.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - out_sum=0; operand registers, chunk index and carry register cleared.
  - Reset mid-operation abandons the operation; no partial result is ever presented.
- FSM states:
  - IDLE: in_ready=1. On in_valid: latch in_0/in_1 (zero-padded to NCHUNK*CHUNK bits), idx=0, carry=0, result=0, go to ADD.
  - ADD: in_ready=0, busy=1. Each cycle: {carry, result[idx]} = op0[idx] + op1[idx] + carry, over CHUNK-bit chunks; idx++.
    - The cycle with idx=NCHUNK-1 writes the final carry into bit NCHUNK*CHUNK of the internal result; transition to DONE.
  - DONE: out_valid=1, out_sum=result[WIDTH:0].
    - out_ready=0: hold out_sum stable, in_ready=0.
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=1 and in_valid=1: in_ready=1; hand off the old result and latch the new pair in the same edge; go to ADD (back-to-back, no bubble).
- Latency:
  - Accept edge at cycle 0; out_valid rises after the NCHUNK-th ADD edge, i.e. exactly NCHUNK cycles after acceptance.
  - Throughput: one result per NCHUNK+1 cycles with out_ready held high.
- Width rules:
  - The partial last chunk is zero-padded; padding bits never reach out_sum.
  - The sum bits above WIDTH fold into out_sum[WIDTH]; it is exact, since in_0+in_1 < 2^(WIDTH+1).
- Input capture: in_0/in_1 are sampled only on the accept edge; changes during ADD/DONE have no effect.
- in_valid held during ADD is ignored, not queued; the producer must keep it high until in_ready.
- in_ready is combinational on state and out_ready only; no combinational path from in_valid to in_ready.
- out_valid, out_sum and busy are registered.

Decomposition:
- Shared package csa_pkg:
  - resolver state enum {IDLE, ADD, DONE}.
  - function nchunk(width, chunk).
  - localparams for the default WIDTH/CHUNK used by compressor rows.
- One natural sub-module: csa_resolver_chunk. Combinational CHUNK-bit adder with carry-in and carry-out, instantiated once and muxed by idx.

Test Plan:
- Accept 0x00001 + 0x1FFFF -> out_sum=0x20000; out_valid exactly 5 cycles after accept edge; carry ripples through all 5 chunks.
- Accept 0x1FFFF + 0x1FFFF -> out_sum=0x3FFFE; checks the top-bit fold from the 1-bit last chunk.
- Accept 0x0ABCD + 0x05432 -> out_sum=0x0FFFF; during ADD, drive in_0=0x1FFFF and hold in_valid -> result unchanged, no second accept while busy=1.
- Backpressure: result 0x3FFFE with out_ready=0 for 3 cycles -> out_sum stable, in_ready=0. Then out_ready=1 with in_valid=1 (0x00002+0x00003) -> same-edge handoff; next out_sum=0x00005 five cycles later.
- Reset low during ADD (idx=2) -> immediately out_valid=0, busy=0, in_ready=1, out_sum=0. After release, 0x00010+0x00020 -> 0x00030 with normal latency.
- Parameter sweep CHUNK=1 and CHUNK=17 with 0x1FFFF+0x00001 -> out_sum=0x20000 after 17 and 1 cycles respectively.
